// File: rtl/grey_window_3x3_if.sv
// rtl/grey_window_3x3_if.sv - pixel-in / window-out bundle for grey_window_3x3
interface grey_window_3x3_if #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int PIX_W = 4
);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   logic [PIX_W-1:0]   pixel_in;
   logic               in_valid;
   logic [9*PIX_W-1:0] window_out;
   logic               out_valid;
   logic [COL_W-1:0]   center_col;
   logic [ROW_W-1:0]   center_row;
   logic               frame_done;

   modport master (
      output pixel_in, in_valid,
      input  window_out, out_valid, center_col, center_row, frame_done
   );

   modport slave (
      input  pixel_in, in_valid,
      output window_out, out_valid, center_col, center_row, frame_done
   );
endinterface

// File: rtl/grey_window_3x3.sv
// rtl/grey_window_3x3.sv - two-line buffer emitting a 3x3 grey window per interior pixel
module grey_window_3x3 #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int PIX_W = 4
) (
   input logic               clk,
   input logic               rst,
   grey_window_3x3_if.slave  bus
);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic [PIX_W-1:0]   lb_a [IMG_W];
   logic [PIX_W-1:0]   lb_b [IMG_W];
   logic [PIX_W-1:0]   trip [3];
   logic [9*PIX_W-1:0] window;
   logic [9*PIX_W-1:0] window_next;
   logic               out_valid;
   logic [COL_W-1:0]   center_col;
   logic [ROW_W-1:0]   center_row;
   logic               frame_done;
   logic               accept;
   logic               last_col;
   logic               last_row;
   logic               emit;

   assign accept   = bus.in_valid;
   assign last_col = (col == COL_W'(IMG_W - 1));
   assign last_row = (row == ROW_W'(IMG_H - 1));
   assign emit     = (row >= ROW_W'(2)) && (col >= COL_W'(2));

   // Column triplet: oldest line on top, incoming pixel at the bottom
   assign trip[0] = lb_b[col];
   assign trip[1] = lb_a[col];
   assign trip[2] = bus.pixel_in;

   always_comb begin
      window_next = window;
      for (int r = 0; r < 3; r++) begin
         window_next[PIX_W*(3*r+0) +: PIX_W] = window[PIX_W*(3*r+1) +: PIX_W];
         window_next[PIX_W*(3*r+1) +: PIX_W] = window[PIX_W*(3*r+2) +: PIX_W];
         window_next[PIX_W*(3*r+2) +: PIX_W] = trip[r];
      end
   end

   // Line RAMs are left uninitialised; row gating keeps stale contents from reaching the output
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         lb_b[col] <= lb_a[col];
         lb_a[col] <= bus.pixel_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         window     <= '0;
         out_valid  <= 1'b0;
         center_col <= '0;
         center_row <= '0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (accept) begin
            window <= window_next;
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
            if (emit) begin
               out_valid  <= 1'b1;
               center_col <= col - COL_W'(1);
               center_row <= row - ROW_W'(1);
               frame_done <= last_col && last_row;
            end
         end
      end
   end

   assign bus.window_out = window;
   assign bus.out_valid  = out_valid;
   assign bus.center_col = center_col;
   assign bus.center_row = center_row;
   assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_grey_window_3x3.sv
// tb/tb_grey_window_3x3.sv - directed self-checking bench for grey_window_3x3 on a 4x4 frame
module tb_grey_window_3x3;
   localparam int W = 4;
   localparam int H = 4;
   localparam int P = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   grey_window_3x3_if #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) bus ();

   grey_window_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Window expected after accepting (rr,cc) when pixel = 4*row+col (or 15 minus that)
   function automatic logic [35:0] exp_win(input int rr, input int cc, input bit inv);
      logic [35:0] w;
      int          v;
      w = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            v = 4 * (rr - 2 + r) + (cc - 2 + c);
            if (inv) v = 15 - v;
            w[4*(3*r+c) +: 4] = 4'(v);
         end
      end
      return w;
   endfunction

   task automatic tick(input logic r, input logic [3:0] pix, input logic v);
      rst          = r;
      bus.pixel_in = pix;
      bus.in_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_zero(input string nm);
      check_eq({nm, ".valid"},  64'(bus.out_valid),  64'd0);
      check_eq({nm, ".window"}, 64'(bus.window_out), 64'd0);
      check_eq({nm, ".crow"},   64'(bus.center_row), 64'd0);
      check_eq({nm, ".ccol"},   64'(bus.center_col), 64'd0);
      check_eq({nm, ".fdone"},  64'(bus.frame_done), 64'd0);
   endtask

   task automatic run_frame(input bit gap, input bit inv, input string nm);
      int          strobes;
      int          dones;
      bit          emit;
      logic [3:0]  pix;
      logic [35:0] ew;
      strobes = 0;
      dones   = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            pix = inv ? 4'(15 - 4*r - c) : 4'(4*r + c);
            tick(1'b0, pix, 1'b1);
            emit = (r >= 2) && (c >= 2);
            ew   = exp_win(r, c, inv);
            if (bus.out_valid) strobes++;
            if (bus.frame_done) dones++;
            check_eq($sformatf("%s.valid(%0d,%0d)", nm, r, c), 64'(bus.out_valid), 64'(emit));
            if (emit) begin
               check_eq($sformatf("%s.win(%0d,%0d)", nm, r, c), 64'(bus.window_out), 64'(ew));
               check_eq($sformatf("%s.crow(%0d,%0d)", nm, r, c), 64'(bus.center_row), 64'(r - 1));
               check_eq($sformatf("%s.ccol(%0d,%0d)", nm, r, c), 64'(bus.center_col), 64'(c - 1));
               check_eq($sformatf("%s.fdone(%0d,%0d)", nm, r, c), 64'(bus.frame_done),
                        64'((r == H-1) && (c == W-1)));
            end else begin
               check_eq($sformatf("%s.fdone(%0d,%0d)", nm, r, c), 64'(bus.frame_done), 64'd0);
            end
            if (gap) begin
               tick(1'b0, ~pix, 1'b0);
               check_eq($sformatf("%s.gapvalid(%0d,%0d)", nm, r, c), 64'(bus.out_valid), 64'd0);
               check_eq($sformatf("%s.gapfdone(%0d,%0d)", nm, r, c), 64'(bus.frame_done), 64'd0);
               if (emit) begin
                  check_eq($sformatf("%s.holdwin(%0d,%0d)", nm, r, c), 64'(bus.window_out), 64'(ew));
                  check_eq($sformatf("%s.holdrow(%0d,%0d)", nm, r, c), 64'(bus.center_row), 64'(r - 1));
                  check_eq($sformatf("%s.holdcol(%0d,%0d)", nm, r, c), 64'(bus.center_col), 64'(c - 1));
               end
            end
         end
      end
      check_eq({nm, ".strobes"}, 64'(strobes), 64'((W-2)*(H-2)));
      check_eq({nm, ".dones"},   64'(dones),   64'd1);
   endtask

   initial begin
      rst          = 1'b1;
      bus.pixel_in = '0;
      bus.in_valid = 1'b0;

      tick(1'b1, 4'hA, 1'b1);
      tick(1'b1, 4'hA, 1'b1);
      check_idle_zero("reset");

      run_frame(1'b0, 1'b0, "cont");
      run_frame(1'b1, 1'b0, "gap");
      run_frame(1'b0, 1'b1, "inv");

      // Seven accepted pixels, then reset with a live pixel that must be dropped
      for (int i = 0; i < 7; i++) begin
         tick(1'b0, 4'(i + 3), 1'b1);
         check_eq($sformatf("part.valid%0d", i), 64'(bus.out_valid), 64'd0);
      end
      tick(1'b1, 4'h9, 1'b1);
      check_idle_zero("midrst");
      run_frame(1'b0, 1'b0, "post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
